// File: rtl/chess_clock_pkg.sv
// Shared widths, limits and FSM encoding for the chess time counter slice.
package chess_clock_pkg;

  localparam int unsigned MIN_W   = 7;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 99;

  typedef enum logic [1:0] {
    IDLE,
    RUN_A,
    RUN_B,
    OVER
  } state_e;

  // True when one more decrement reaches 00:00.
  function automatic logic is_last_sec(input logic [MIN_W-1:0] m,
                                       input logic [SEC_W-1:0] s);
    return (m == '0) && (s == SEC_W'(1));
  endfunction

endpackage

// File: rtl/chess_time_counter_if.sv
// Bundle between the chess clock controller (master) and the time counter (slave).
interface chess_time_counter_if;
  import chess_clock_pkg::*;

  logic             time_a;
  logic             time_b;
  logic             clr;
  logic [MIN_W-1:0] a_min;
  logic [SEC_W-1:0] a_sec;
  logic [MIN_W-1:0] b_min;
  logic [SEC_W-1:0] b_sec;
  logic             a_flag;
  logic             b_flag;
  logic             game_over;

  modport master (
    output time_a, time_b, clr,
    input  a_min, a_sec, b_min, b_sec, a_flag, b_flag, game_over
  );

  modport slave (
    input  time_a, time_b, clr,
    output a_min, a_sec, b_min, b_sec, a_flag, b_flag, game_over
  );

endinterface

// File: rtl/chess_mmss_down.sv
// One player's minutes:seconds register with load, decrement and (CHESS_INCREMENT_EN) increment.
module chess_mmss_down
  import chess_clock_pkg::*;
#(
  parameter int unsigned INIT_MIN = 5
`ifdef CHESS_INCREMENT_EN
  ,
  parameter int unsigned INC_SEC  = 2
`endif
) (
  input  logic             clk_i,
  input  logic             load_i,
  input  logic             dec_i,
`ifdef CHESS_INCREMENT_EN
  input  logic             inc_i,
`endif
  output logic [MIN_W-1:0] min_o,
  output logic [SEC_W-1:0] sec_o,
  output logic             zero_o
);

  logic [MIN_W-1:0] min_q, min_d;
  logic [SEC_W-1:0] sec_q, sec_d;
`ifdef CHESS_INCREMENT_EN
  logic [SEC_W:0]   sec_sum;
`endif

  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
`ifdef CHESS_INCREMENT_EN
    sec_sum = {1'b0, sec_q} + (SEC_W+1)'(INC_SEC);
`endif
    if (load_i) begin
      min_d = MIN_W'(INIT_MIN);
      sec_d = '0;
    end
`ifdef CHESS_INCREMENT_EN
    else if (inc_i) begin
      if (sec_sum > (SEC_W+1)'(SEC_MAX)) begin
        // Carry into minutes, saturating at 99:59.
        if (min_q >= MIN_W'(MIN_MAX)) begin
          min_d = MIN_W'(MIN_MAX);
          sec_d = SEC_W'(SEC_MAX);
        end else begin
          min_d = min_q + 1'b1;
          sec_d = SEC_W'(sec_sum - (SEC_W+1)'(SEC_MAX + 1));
        end
      end else begin
        sec_d = SEC_W'(sec_sum);
      end
    end
`endif
    else if (dec_i) begin
      if (sec_q != '0) begin
        sec_d = sec_q - 1'b1;
      end else if (min_q != '0) begin
        min_d = min_q - 1'b1;
        sec_d = SEC_W'(SEC_MAX);
      end
    end
  end

  // Reset arrives through load_i, which the parent drives from reset | clr.
  always_ff @(posedge clk_i) begin
    min_q <= min_d;
    sec_q <= sec_d;
  end

  assign min_o  = min_q;
  assign sec_o  = sec_q;
  assign zero_o = (min_q == '0) && (sec_q == '0);

endmodule

// File: rtl/chess_time_counter.sv
// Two-player countdown with prescaler, sticky timeout flags and game-over FSM.
// Optional per-turn increment is enabled by defining CHESS_INCREMENT_EN.
module chess_time_counter
  import chess_clock_pkg::*;
#(
  parameter int unsigned INIT_MIN      = 5,
  parameter int unsigned TICKS_PER_SEC = 4,
  parameter int unsigned INC_SEC       = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  chess_time_counter_if.slave  bus
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TLAST = PW'(TICKS_PER_SEC - 1);

  if ((INIT_MIN < 1) || (INIT_MIN > MIN_MAX)) begin : g_bad_init_min
    $error("INIT_MIN must be 1..99");
  end
  if (TICKS_PER_SEC < 1) begin : g_bad_ticks
    $error("TICKS_PER_SEC must be >= 1");
  end
  if (INC_SEC > SEC_MAX) begin : g_bad_inc
    $error("INC_SEC must be 0..59");
  end

  state_e           state_q, state_d, live_s;
  logic [PW-1:0]    presc_q, presc_d, presc_eff;
  logic             a_flag_q, a_flag_d, b_flag_q, b_flag_d;
  logic             running, tick, tick_a, tick_b;
  logic             load;
  logic [MIN_W-1:0] a_min_s, b_min_s;
  logic [SEC_W-1:0] a_sec_s, b_sec_s;
  logic             a_zero, b_zero, a_last, b_last;
`ifdef CHESS_INCREMENT_EN
  logic             inc_a_q, inc_a_d, inc_b_q, inc_b_d;
`endif

  assign load   = reset | bus.clr;
  assign a_last = is_last_sec(a_min_s, a_sec_s);
  assign b_last = is_last_sec(b_min_s, b_sec_s);

  // live_s decodes this cycle's inputs while state_q holds last cycle's state, so a
  // turn change zeroes the prescaler in the same cycle and the first decrement lands
  // TICKS_PER_SEC edges after the enable rises.
  always_comb begin
    live_s = IDLE;
    if (state_q == OVER)                     live_s = OVER;
    else if (bus.time_a && !bus.time_b)      live_s = RUN_A;
    else if (bus.time_b && !bus.time_a)      live_s = RUN_B;

    running   = (live_s == RUN_A) || (live_s == RUN_B);
    presc_eff = (live_s != state_q) ? '0 : presc_q;
    tick      = running && (presc_eff == TLAST);
    tick_a    = tick && (live_s == RUN_A) && !a_zero;
    tick_b    = tick && (live_s == RUN_B) && !b_zero;
`ifdef CHESS_INCREMENT_EN
    tick_a    = tick_a && !inc_a_q;
    tick_b    = tick_b && !inc_b_q;
    inc_a_d   = (state_q == RUN_A) && (live_s != RUN_A) && !(a_flag_q || b_flag_q);
    inc_b_d   = (state_q == RUN_B) && (live_s != RUN_B) && !(a_flag_q || b_flag_q);
`endif

    presc_d = presc_eff;
    if (running) presc_d = tick ? '0 : presc_eff + 1'b1;

    a_flag_d = a_flag_q || (tick_a && a_last);
    b_flag_d = b_flag_q || (tick_b && b_last);
    state_d  = (a_flag_d || b_flag_d) ? OVER : live_s;
  end

  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      a_flag_q <= 1'b0;
      b_flag_q <= 1'b0;
`ifdef CHESS_INCREMENT_EN
      inc_a_q  <= 1'b0;
      inc_b_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      a_flag_q <= a_flag_d;
      b_flag_q <= b_flag_d;
`ifdef CHESS_INCREMENT_EN
      inc_a_q  <= inc_a_d;
      inc_b_q  <= inc_b_d;
`endif
    end
  end

  chess_mmss_down #(
    .INIT_MIN (INIT_MIN)
`ifdef CHESS_INCREMENT_EN
    ,
    .INC_SEC  (INC_SEC)
`endif
  ) u_player_a (
    .clk_i  (clk),
    .load_i (load),
    .dec_i  (tick_a),
`ifdef CHESS_INCREMENT_EN
    .inc_i  (inc_a_q),
`endif
    .min_o  (a_min_s),
    .sec_o  (a_sec_s),
    .zero_o (a_zero)
  );

  chess_mmss_down #(
    .INIT_MIN (INIT_MIN)
`ifdef CHESS_INCREMENT_EN
    ,
    .INC_SEC  (INC_SEC)
`endif
  ) u_player_b (
    .clk_i  (clk),
    .load_i (load),
    .dec_i  (tick_b),
`ifdef CHESS_INCREMENT_EN
    .inc_i  (inc_b_q),
`endif
    .min_o  (b_min_s),
    .sec_o  (b_sec_s),
    .zero_o (b_zero)
  );

  assign bus.a_min     = a_min_s;
  assign bus.a_sec     = a_sec_s;
  assign bus.b_min     = b_min_s;
  assign bus.b_sec     = b_sec_s;
  assign bus.a_flag    = a_flag_q;
  assign bus.b_flag    = b_flag_q;
  assign bus.game_over = a_flag_q || b_flag_q;

endmodule

// File: tb/tb_chess_time_counter.sv
// Scoreboard bench: a seconds-based model predicts every cycle, a monitor compares.
module tb_chess_time_counter;
  import chess_clock_pkg::*;

  localparam int unsigned INIT_MIN = 1;
  localparam int unsigned TPS      = 4;
  localparam int unsigned INC      = 2;

  typedef struct packed {
    logic [6:0] a_min;
    logic [5:0] a_sec;
    logic [6:0] b_min;
    logic [5:0] b_sec;
    logic       a_flag;
    logic       b_flag;
    logic       game_over;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chess_time_counter_if bus_if ();

  chess_time_counter #(
    .INIT_MIN      (INIT_MIN),
    .TICKS_PER_SEC (TPS),
    .INC_SEC       (INC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Model: remaining time in whole seconds, plus how long the current runner has run.
  int m_ta, m_tb, m_prev, m_run;
  bit m_fa, m_fb;
`ifdef CHESS_INCREMENT_EN
  bit m_pa, m_pb;
`endif

  task automatic model_step(input bit r, input bit c, input bit a, input bit b);
    int who;
    bit over;
    if (r || c) begin
      m_ta = INIT_MIN * 60;
      m_tb = INIT_MIN * 60;
      m_fa = 0;
      m_fb = 0;
      m_prev = 0;
      m_run = 0;
`ifdef CHESS_INCREMENT_EN
      m_pa = 0;
      m_pb = 0;
`endif
    end else begin
      over = m_fa || m_fb;
      who  = over ? 0 : (a && !b) ? 1 : (b && !a) ? 2 : 0;
`ifdef CHESS_INCREMENT_EN
      if (m_pa) m_ta = (m_ta + INC > 5999) ? 5999 : m_ta + INC;
      if (m_pb) m_tb = (m_tb + INC > 5999) ? 5999 : m_tb + INC;
      m_pa = (m_prev == 1) && (who != 1) && !over;
      m_pb = (m_prev == 2) && (who != 2) && !over;
`endif
      if (who != m_prev) m_run = 0;
      if (who != 0) begin
        m_run++;
        if (m_run == TPS) begin
          m_run = 0;
          if (who == 1 && m_ta > 0) begin
            m_ta--;
            if (m_ta == 0) m_fa = 1;
          end
          if (who == 2 && m_tb > 0) begin
            m_tb--;
            if (m_tb == 0) m_fb = 1;
          end
        end
      end
      m_prev = who;
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.a_min     = 7'(m_ta / 60);
    o.a_sec     = 6'(m_ta % 60);
    o.b_min     = 7'(m_tb / 60);
    o.b_sec     = 6'(m_tb % 60);
    o.a_flag    = m_fa;
    o.b_flag    = m_fb;
    o.game_over = m_fa || m_fb;
    return o;
  endfunction

  task automatic drive(input bit r, input bit c, input bit a, input bit b);
    @(negedge clk);
    reset         = r;
    bus_if.clr    = c;
    bus_if.time_a = a;
    bus_if.time_b = b;
    model_step(r, c, a, b);
    exp_q.push_back(model_obs());
  endtask

  // Monitor: the DUT presents its outputs every cycle; pop one expectation per edge.
  initial begin
    obs_t e, got;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {bus_if.a_min, bus_if.a_sec, bus_if.b_min, bus_if.b_sec,
               bus_if.a_flag, bus_if.b_flag, bus_if.game_over};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs @cyc %0d: got a=%0d:%0d b=%0d:%0d af=%b bf=%b go=%b, want a=%0d:%0d b=%0d:%0d af=%b bf=%b go=%b",
                   cyc, got.a_min, got.a_sec, got.b_min, got.b_sec, got.a_flag, got.b_flag, got.game_over,
                   e.a_min, e.a_sec, e.b_min, e.b_sec, e.a_flag, e.b_flag, e.game_over);
        end
      end
    end
  end

  initial begin
    int unsigned kind, len;
    bit a, b;
    reset         = 1'b1;
    bus_if.clr    = 1'b0;
    bus_if.time_a = 1'b0;
    bus_if.time_b = 1'b0;

    // Reset held, then A runs 8 cycles (two decrements).
    repeat (2) drive(1, 0, 0, 0);
    repeat (8) drive(0, 0, 1, 0);
    repeat (2) drive(0, 0, 0, 0);

    // A runs out after 240 cycles; later activity is ignored until clr.
    drive(1, 0, 0, 0);
    repeat (240) drive(0, 0, 1, 0);
    repeat (10) drive(0, 0, 0, 1);
    repeat (5) drive(0, 0, 1, 0);
    repeat (3) drive(0, 0, 1, 1);
    drive(0, 1, 0, 0);
    repeat (2) drive(0, 0, 0, 0);

    // Both enables together: nothing moves.
    repeat (20) drive(0, 0, 1, 1);

    // Turn change drops B's sub-second remainder.
    drive(1, 0, 0, 0);
    repeat (6) drive(0, 0, 0, 1);
    repeat (4) drive(0, 0, 1, 0);
    repeat (3) drive(0, 0, 0, 0);

    // Reset mid-countdown at 00:37, then restart from a clean prescaler.
    drive(1, 0, 0, 0);
    repeat (92) drive(0, 0, 1, 0);
    drive(1, 0, 1, 0);
    repeat (5) drive(0, 0, 1, 0);

    // Randomized turns with occasional clr / reset.
    drive(1, 0, 0, 0);
    for (int s = 0; s < 200; s++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 40);
      a    = (kind <= 3) || (kind == 8);
      b    = ((kind >= 4) && (kind <= 7)) || (kind == 8);
      if ($urandom_range(0, 24) == 0) drive(0, 1, a, b);
      if ($urandom_range(0, 59) == 0) drive(1, 0, a, b);
      for (int unsigned k = 0; k < len; k++) begin
        if ($urandom_range(0, 15) == 0) drive(0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        else drive(0, 0, a, b);
      end
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
